// File: rtl/color_lookup_arbiter.sv
// color_lookup_arbiter
//
// Shares one combinational iteration-to-RGB palette among NUM_ENG Mandelbrot
// iteration engines. A round-robin arbiter grants one finished pixel per
// cycle into stage A. Stage A registers the pixel and drives the palette index,
// with the colour-cycling offset already added. Stage B captures the returned
// palette colour, forces in-set pixels to black, and presents {addr, rgb} to
// the framebuffer writer.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   eng_valid / eng_ready   per-engine request / one-hot grant
//   eng_iter, eng_inset,    per-engine iteration count, in-set flag and pixel
//   eng_addr                address, packed engine-major
//   cycle_en, frame_tick    palette rotation enable and frame-start pulse
//   pal_index               registered palette lookup index
//   pal_red/green/blue      combinational palette return for pal_index
//   fb_valid/fb_ready       output handshake
//   fb_addr, fb_rgb         output pixel address and {red, green, blue}
//   cur_offset              current rotation offset (status)
module color_lookup_arbiter #(
    parameter int unsigned NUM_ENG = 4,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned ITER_W  = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_ENG-1:0]         eng_valid,
    output logic [NUM_ENG-1:0]         eng_ready,
    input  logic [NUM_ENG*ITER_W-1:0]  eng_iter,
    input  logic [NUM_ENG-1:0]         eng_inset,
    input  logic [NUM_ENG*ADDR_W-1:0]  eng_addr,
    input  logic                       cycle_en,
    input  logic                       frame_tick,
    output logic [ITER_W-1:0]          pal_index,
    input  logic [7:0]                 pal_red,
    input  logic [7:0]                 pal_green,
    input  logic [7:0]                 pal_blue,
    output logic                       fb_valid,
    input  logic                       fb_ready,
    output logic [ADDR_W-1:0]          fb_addr,
    output logic [23:0]                fb_rgb,
    output logic [ITER_W-1:0]          cur_offset
);

    localparam int unsigned PTR_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    // State
    logic [PTR_W-1:0]  rr_q;
    logic              a_valid_q;
    logic [ADDR_W-1:0] a_addr_q;
    logic              a_inset_q;
    logic [ITER_W-1:0] pal_index_q;
    logic [ITER_W-1:0] offset_q;
    logic              fb_valid_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [23:0]       fb_rgb_q;

    // Per-engine views of the packed buses
    logic [ITER_W-1:0] iter_arr [NUM_ENG];
    logic [ADDR_W-1:0] addr_arr [NUM_ENG];

    always_comb begin
        for (int i = 0; i < NUM_ENG; i++) begin
            iter_arr[i] = eng_iter[i*ITER_W +: ITER_W];
            addr_arr[i] = eng_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Pipeline advance
    logic advance_b;
    logic advance_a;

    assign advance_b = !fb_valid_q || fb_ready;
    assign advance_a = !a_valid_q || advance_b;

    // Round-robin scan starting at rr_q
    logic             found;
    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] gidx;
    logic             grant;
    logic [PTR_W-1:0] rr_next;

    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        gidx     = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            scan_idx = PTR_W'((int'(rr_q) + k) % int'(NUM_ENG));
            if (!found && eng_valid[scan_idx]) begin
                found = 1'b1;
                gidx  = scan_idx;
            end
        end
    end

    // Gating with rst_n keeps the grant silent while reset is held low.
    assign grant   = found && advance_a && rst_n;
    assign rr_next = (gidx == PTR_W'(NUM_ENG - 1)) ? '0 : gidx + 1'b1;

    always_comb begin
        eng_ready = '0;
        if (grant) begin
            eng_ready[gidx] = 1'b1;
        end
    end

    // Stage A, pointer and palette index. pal_index only moves on a grant so
    // the palette return stays aligned with the pixel held in stage A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= '0;
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_inset_q   <= 1'b0;
            pal_index_q <= '0;
        end else if (advance_a) begin
            a_valid_q <= grant;
            if (grant) begin
                rr_q        <= rr_next;
                a_addr_q    <= addr_arr[gidx];
                a_inset_q   <= eng_inset[gidx];
                pal_index_q <= iter_arr[gidx] + offset_q;
            end
        end
    end

    // Rotation offset; a grant in the same cycle already used the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else if (frame_tick) begin
            offset_q <= cycle_en ? offset_q + 1'b1 : '0;
        end
    end

    // Stage B
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_valid_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_rgb_q   <= '0;
        end else if (advance_b) begin
            fb_valid_q <= a_valid_q;
            fb_addr_q  <= a_addr_q;
            fb_rgb_q   <= a_inset_q ? 24'h000000 : {pal_red, pal_green, pal_blue};
        end
    end

    assign pal_index  = pal_index_q;
    assign cur_offset = offset_q;
    assign fb_valid   = fb_valid_q;
    assign fb_addr    = fb_addr_q;
    assign fb_rgb     = fb_rgb_q;

endmodule

// File: tb/tb_color_lookup_arbiter.sv
// Directed self-checking bench for color_lookup_arbiter (NUM_ENG=4, ADDR_W=19,
// ITER_W=5). The palette is modelled as a fixed combinational function of
// pal_index; expected colours come from the same table applied to the
// hand-computed index.
module tb_color_lookup_arbiter;

    localparam int unsigned NUM_ENG = 4;
    localparam int unsigned ADDR_W  = 19;
    localparam int unsigned ITER_W  = 5;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_ENG-1:0]        eng_valid;
    logic [NUM_ENG-1:0]        eng_ready;
    logic [NUM_ENG*ITER_W-1:0] eng_iter;
    logic [NUM_ENG-1:0]        eng_inset;
    logic [NUM_ENG*ADDR_W-1:0] eng_addr;
    logic                      cycle_en;
    logic                      frame_tick;
    logic [ITER_W-1:0]         pal_index;
    logic [7:0]                pal_red;
    logic [7:0]                pal_green;
    logic [7:0]                pal_blue;
    logic                      fb_valid;
    logic                      fb_ready;
    logic [ADDR_W-1:0]         fb_addr;
    logic [23:0]               fb_rgb;
    logic [ITER_W-1:0]         cur_offset;

    int n_total = 0;
    int n_pass  = 0;

    color_lookup_arbiter #(
        .NUM_ENG (NUM_ENG),
        .ADDR_W  (ADDR_W),
        .ITER_W  (ITER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eng_valid  (eng_valid),
        .eng_ready  (eng_ready),
        .eng_iter   (eng_iter),
        .eng_inset  (eng_inset),
        .eng_addr   (eng_addr),
        .cycle_en   (cycle_en),
        .frame_tick (frame_tick),
        .pal_index  (pal_index),
        .pal_red    (pal_red),
        .pal_green  (pal_green),
        .pal_blue   (pal_blue),
        .fb_valid   (fb_valid),
        .fb_ready   (fb_ready),
        .fb_addr    (fb_addr),
        .fb_rgb     (fb_rgb),
        .cur_offset (cur_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Palette ROM model: never black for any index.
    function automatic logic [23:0] rgb_of(input logic [ITER_W-1:0] idx);
        logic [7:0] r;
        r = {idx, 3'b101};
        return {r, ~r, {3'b000, idx} ^ 8'h3c};
    endfunction

    assign {pal_red, pal_green, pal_blue} = rgb_of(pal_index);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int i, input logic [ITER_W-1:0] it,
                           input logic [ADDR_W-1:0] ad, input logic ins);
        eng_iter[i*ITER_W +: ITER_W] = it;
        eng_addr[i*ADDR_W +: ADDR_W] = ad;
        eng_inset[i]                 = ins;
    endtask

    initial begin
        rst_n      = 1'b0;
        eng_valid  = '0;
        eng_iter   = '0;
        eng_inset  = '0;
        eng_addr   = '0;
        cycle_en   = 1'b0;
        frame_tick = 1'b0;
        fb_ready   = 1'b1;

        // Reset state; requests are ignored while rst_n is low
        step();
        eng_valid = 4'b1111;
        #1;
        check("rst_eng_ready", 64'(eng_ready), 64'h0);
        step();
        check("rst_fb_valid", 64'(fb_valid), 64'h0);
        check("rst_fb_addr", 64'(fb_addr), 64'h0);
        check("rst_fb_rgb", 64'(fb_rgb), 64'h0);
        check("rst_pal_index", 64'(pal_index), 64'h0);
        check("rst_offset", 64'(cur_offset), 64'h0);
        eng_valid = '0;
        rst_n     = 1'b1;
        step();

        // Engine 2 alone: iter 5, addr 100
        set_eng(2, 5'd5, 19'd100, 1'b0);
        eng_valid = 4'b0100;
        #1;
        check("single_ready", 64'(eng_ready), 64'h4);
        step();
        eng_valid = '0;
        check("single_pal_index", 64'(pal_index), 64'd5);
        check("single_fb_not_yet", 64'(fb_valid), 64'h0);
        step();
        check("single_fb_valid", 64'(fb_valid), 64'h1);
        check("single_fb_addr", 64'(fb_addr), 64'd100);
        check("single_fb_rgb", 64'(fb_rgb), 64'(rgb_of(5'd5)));
        step();
        check("single_fb_drop", 64'(fb_valid), 64'h0);

        // Fresh reset so the pointer restarts at engine 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // All engines continuously valid: grant order 0,1,2,3,0,1
        for (int i = 0; i < 4; i++) set_eng(i, 5'(i + 1), 19'(200 + i), 1'b0);
        eng_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), 64'(eng_ready), 64'(4'b0001 << (k % 4)));
            step();
            check($sformatf("rr_pal_%0d", k), 64'(pal_index), 64'((k % 4) + 1));
            if (k >= 1) begin
                check($sformatf("rr_fb_valid_%0d", k), 64'(fb_valid), 64'h1);
                check($sformatf("rr_fb_addr_%0d", k), 64'(fb_addr), 64'(200 + (k - 1) % 4));
                check($sformatf("rr_fb_rgb_%0d", k), 64'(fb_rgb),
                      64'(rgb_of(5'(((k - 1) % 4) + 1))));
            end
        end
        eng_valid = '0;
        step();
        check("rr_last_addr", 64'(fb_addr), 64'd201);
        step();
        check("rr_drained", 64'(fb_valid), 64'h0);
        // rr pointer now 2

        // In-set pixel on engine 0 is black
        set_eng(0, 5'd12, 19'd300, 1'b1);
        eng_valid = 4'b0001;
        #1;
        check("inset_ready", 64'(eng_ready), 64'h1);
        step();
        eng_valid = '0;
        check("inset_pal_index", 64'(pal_index), 64'd12);
        step();
        check("inset_fb_valid", 64'(fb_valid), 64'h1);
        check("inset_fb_addr", 64'(fb_addr), 64'd300);
        check("inset_fb_rgb", 64'(fb_rgb), 64'h0);
        eng_inset = '0;
        step();
        // rr pointer now 1, pipeline empty

        // Backpressure: fb_ready low for 5 cycles
        for (int i = 0; i < 4; i++) set_eng(i, 5'(i + 1), 19'(400 + i), 1'b0);
        eng_valid = 4'b1111;
        fb_ready  = 1'b0;
        #1;
        check("bp_grant0", 64'(eng_ready), 64'h2);
        step();
        check("bp_grant1", 64'(eng_ready), 64'h4);
        step();
        for (int c = 2; c < 5; c++) begin
            check($sformatf("bp_stall_ready_%0d", c), 64'(eng_ready), 64'h0);
            check($sformatf("bp_stall_valid_%0d", c), 64'(fb_valid), 64'h1);
            check($sformatf("bp_stall_addr_%0d", c), 64'(fb_addr), 64'd401);
            check($sformatf("bp_stall_rgb_%0d", c), 64'(fb_rgb), 64'(rgb_of(5'd2)));
            step();
        end
        eng_valid = '0;
        fb_ready  = 1'b1;
        #1;
        check("bp_release_addr", 64'(fb_addr), 64'd401);
        step();
        check("bp_drain_valid", 64'(fb_valid), 64'h1);
        check("bp_drain_addr", 64'(fb_addr), 64'd402);
        check("bp_drain_rgb", 64'(fb_rgb), 64'(rgb_of(5'd3)));
        step();
        check("bp_drain_empty", 64'(fb_valid), 64'h0);
        // rr pointer now 3

        // Rotation: 33 frame ticks wraps the offset to 1
        cycle_en = 1'b1;
        for (int t = 1; t <= 33; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (t == 31) check("rot_31", 64'(cur_offset), 64'd31);
            if (t == 32) check("rot_32_wrap", 64'(cur_offset), 64'd0);
        end
        check("rot_33", 64'(cur_offset), 64'd1);

        // iter 31 at offset 1 wraps to index 0
        set_eng(3, 5'd31, 19'd500, 1'b0);
        eng_valid = 4'b1000;
        #1;
        check("rot_ready", 64'(eng_ready), 64'h8);
        step();
        eng_valid = '0;
        check("rot_pal_wrap", 64'(pal_index), 64'd0);
        step();
        check("rot_fb_addr", 64'(fb_addr), 64'd500);
        check("rot_fb_rgb", 64'(fb_rgb), 64'(rgb_of(5'd0)));

        // Grant and frame_tick together: old offset used, offset still advances
        set_eng(0, 5'd10, 19'd600, 1'b0);
        eng_valid  = 4'b0001;
        frame_tick = 1'b1;
        step();
        eng_valid  = '0;
        frame_tick = 1'b0;
        check("tick_grant_pal", 64'(pal_index), 64'd11);
        check("tick_grant_offset", 64'(cur_offset), 64'd2);
        step();
        check("tick_grant_fb_addr", 64'(fb_addr), 64'd600);
        step();

        // frame_tick with cycle_en low clears the offset
        cycle_en   = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("rot_clear", 64'(cur_offset), 64'd0);

        // Make the offset nonzero before the mid-transfer reset
        cycle_en   = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("pre_rst_offset", 64'(cur_offset), 64'd1);

        // Fill A and B under backpressure, then reset
        for (int i = 0; i < 4; i++) set_eng(i, 5'(i + 1), 19'(700 + i), 1'b0);
        eng_valid = 4'b1111;
        fb_ready  = 1'b0;
        step();
        step();
        check("pre_rst_fb_valid", 64'(fb_valid), 64'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(eng_ready), 64'h0);
        step();
        check("mid_rst_fb_valid", 64'(fb_valid), 64'h0);
        check("mid_rst_offset", 64'(cur_offset), 64'd0);
        rst_n    = 1'b1;
        fb_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(eng_ready), 64'h1);
        step();
        eng_valid = '0;
        check("post_rst_no_stale", 64'(fb_valid), 64'h0);
        step();
        check("post_rst_fb_valid", 64'(fb_valid), 64'h1);
        check("post_rst_fb_addr", 64'(fb_addr), 64'd700);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/color_lookup_arbiter.md
Name: color_lookup_arbiter

Overview:
- Shares the single combinational iteration-to-RGB palette lookup among NUM_ENG Mandelbrot iteration engines.
- Grants one engine result per cycle using round-robin arbitration.
- Applies an optional palette-rotation offset (colour cycling, advanced once per frame).
- Forces in-set pixels to black.
- Delivers {address, RGB} words to the framebuffer writer over a valid/ready handshake.
- Sits between the engine array and the framebuffer write port; instantiates nothing and drives the palette index out and reads the palette RGB back.

Parameters:
NUM_ENG, 4, number of requesting iteration engines (2..8)
ADDR_W, 19, framebuffer pixel address width (640x480 fits)
ITER_W, 5, palette index width; palette has 2^ITER_W entries

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
eng_valid  in  NUM_ENG  engine i has a finished pixel
eng_ready  out  NUM_ENG  one-hot grant; transfer when eng_valid[i] & eng_ready[i]
eng_iter  in  NUM_ENG*ITER_W  iteration count, engine i at bits [i*ITER_W +: ITER_W]
eng_inset  in  NUM_ENG  pixel never escaped (in set)
eng_addr  in  NUM_ENG*ADDR_W  pixel address, engine i at [i*ADDR_W +: ADDR_W]
cycle_en  in  1  enable palette rotation
frame_tick  in  1  single-cycle pulse at frame start
pal_index  out  ITER_W  index to palette lookup (registered)
pal_red  in  8  palette red for pal_index (combinational return)
pal_green  in  8  palette green
pal_blue  in  8  palette blue
fb_valid  out  1  output word valid
fb_ready  in  1  framebuffer accepts word
fb_addr  out  ADDR_W  pixel address
fb_rgb  out  24  {red, green, blue}
cur_offset  out  ITER_W  current rotation offset (debug/status)

Behaviour:
- Reset (rst_n low at posedge): fb_valid=0, fb_addr=0, fb_rgb=0, pal_index=0, cur_offset=0, rr pointer=0, stage-A valid=0. eng_ready is all zero while rst_n is low. Reset mid-transfer drops in-flight pixels without emitting them.
- Pipeline: stage A (grant register) and stage B (output register). advance_B = !fb_valid | fb_ready. advance_A = !A_valid | advance_B.
- Arbitration (combinational): when advance_A is high, eng_ready is one-hot for the first requesting engine found scanning from rr pointer upward, modulo NUM_ENG. eng_ready is all zero when advance_A is low or no engine requests. eng_ready never asserts for an engine whose eng_valid is low.
- On a grant of engine g, at the posedge:
  - A_valid=1; A_addr=eng_addr[g]; A_inset=eng_inset[g]
  - pal_index = (eng_iter[g] + cur_offset) mod 2^ITER_W, wrapping (31+1 -> 0)
  - rr pointer = (g+1) mod NUM_ENG
  - With no grant and advance_A high: A_valid=0 and the pointer is unchanged.
- Stage B: on advance_B, fb_valid=A_valid, fb_addr=A_addr, and fb_rgb = A_inset ? 24'h000000 : {pal_red, pal_green, pal_blue}. When fb_valid is high and fb_ready is low, every B register holds stable.
- Latency: handshake at edge T puts the word on fb_* after edge T+1 (two registered stages). Throughput is one pixel per cycle while fb_ready is held high. Output order equals grant order.
- Backpressure: with fb_ready low, at most 2 pixels are held (A and B); afterwards eng_ready stays 0.
- Rotation: on a frame_tick posedge with cycle_en=1, cur_offset increments mod 2^ITER_W. With cycle_en=0, cur_offset resets to 0 on frame_tick. The offset is sampled at grant time, so a pixel granted in the same cycle as frame_tick uses the old offset.
- Simultaneous events: an eng_valid drop without a grant is legal (no latch). Grant and frame_tick in the same cycle both take effect.

Test Plan:
- Reset, then engine 2 alone presents iter=5, addr=100, offset 0: eng_ready=0100; fb_valid two edges later with addr=100 and pal_index observed at 5.
- All 4 engines valid continuously, fb_ready=1: grant order 0,1,2,3,0,1; one fb word per cycle; addresses in the same order.
- eng_inset=1 with iter=12: fb_rgb=000000 regardless of pal_* value.
- fb_ready low for 5 cycles with all engines valid: exactly 2 grants, then eng_ready=0. fb_* stays stable; after release the words drain in order with no loss or duplication.
- cycle_en=1 with 33 frame_ticks: cur_offset reaches 1 (wrap after 31). An iter=31 pixel granted at offset 1 gives pal_index=0. A frame_tick with cycle_en=0 returns offset to 0.
- rst_n low while A and B are both valid: next cycle fb_valid=0, eng_ready=0, cur_offset=0; after release the rr pointer restarts at engine 0.
